alu_mult_sequencer: RTL and testbench

//  Multi-cycle MULT/MULTU controller built on the shared 32-bit alu (AND/OR/ADD/SUB/SLT).
//  - Computes the 64-bit product into HI/LO with no dedicated multiplier.
//  - Issues one alu add/sub per cycle over DATA_WIDTH iterations.
//  - Sits beside the core datapath; the core stalls while busy=1.

---
 rtl/alu_mult_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_mult_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_sequencer.sv
// Multi-cycle MULT/MULTU sequencer that reuses the shared 32-bit alu.
// It does one add or subtract per cycle and shifts the partial product right,
// building the 2*DATA_WIDTH product in HI/LO. Signed operands use radix-2 Booth
// recoding; unsigned operands use plain shift-and-add.
module alu_mult_sequencer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op_signed,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_ALUop,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_CarryOut,
  input  logic                  alu_Overflow
);

  localparam int unsigned CountWidth = $clog2(DATA_WIDTH) + 1;
  localparam logic [CountWidth-1:0] LastStep = CountWidth'(DATA_WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] AluNop = 3'b000;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;

  logic [1:0]            state_q, state_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] m_q, m_d;
  logic                  q_q, q_d;
  logic                  mode_q, mode_d;
  logic                  msb;

  // Status flags decode directly from the state.
  always_comb begin
    busy = (state_q == StCalc) || (state_q == StDone);
    done = (state_q == StDone);
    hi   = hi_q;
    lo   = lo_q;
  end

  // Alu operand/opcode selection for the current step.
  always_comb begin
    alu_A     = '0;
    alu_B     = '0;
    alu_ALUop = AluNop;
    if (state_q == StCalc) begin
      alu_A     = hi_q;
      alu_ALUop = AluAdd;
      if (mode_q) begin
        // Booth pair {current bit, previous bit}: 01 adds M, 10 subtracts M.
        unique case ({lo_q[0], q_q})
          2'b01: alu_B = m_q;
          2'b10: begin
            alu_B     = m_q;
            alu_ALUop = AluSub;
          end
          default: alu_B = '0;
        endcase
      end else begin
        alu_B = lo_q[0] ? m_q : '0;
      end
    end
  end

  // Bit 32 of the true sum: sign corrected by overflow, or the unsigned carry.
  always_comb begin
    msb = mode_q ? (alu_Result[DATA_WIDTH-1] ^ alu_Overflow) : alu_CarryOut;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    q_d     = q_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          m_d     = a;
          hi_d    = '0;
          lo_d    = b;
          q_d     = 1'b0;
          count_d = '0;
          mode_d  = op_signed;
          state_d = StCalc;
        end
      end
      StCalc: begin
        hi_d    = {msb, alu_Result[DATA_WIDTH-1:1]};
        lo_d    = {alu_Result[0], lo_q[DATA_WIDTH-1:1]};
        q_d     = lo_q[0];
        count_d = count_q + 1'b1;
        if (count_q == LastStep) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      q_q     <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Self-checking bench for alu_mult_sequencer: a behavioural alu, a
// transaction-level product model checked every cycle, and directed vectors.
module tb_alu_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [31:0] alu_A, alu_B;
  logic [2:0]  alu_ALUop;
  logic [31:0] alu_Result;
  logic        alu_CarryOut, alu_Overflow;

  int passed = 0;
  int total = 0;

  alu_mult_sequencer #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op_signed    (op_signed),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_ALUop    (alu_ALUop),
    .alu_Result   (alu_Result),
    .alu_CarryOut (alu_CarryOut),
    .alu_Overflow (alu_Overflow)
  );

  always #5 clk = ~clk;

  // Shared 32-bit alu: AND/OR/ADD/SUB/SLT.
  always_comb begin
    logic [32:0] s;
    s            = '0;
    alu_Result   = '0;
    alu_CarryOut = 1'b0;
    alu_Overflow = 1'b0;
    case (alu_ALUop)
      3'b000: alu_Result = alu_A & alu_B;
      3'b001: alu_Result = alu_A | alu_B;
      3'b010: begin
        s            = {1'b0, alu_A} + {1'b0, alu_B};
        alu_Result   = s[31:0];
        alu_CarryOut = s[32];
        alu_Overflow = (alu_A[31] == alu_B[31]) && (s[31] != alu_A[31]);
      end
      3'b110: begin
        s            = {1'b0, alu_A} + {1'b0, ~alu_B} + 33'd1;
        alu_Result   = s[31:0];
        alu_CarryOut = s[32];
        alu_Overflow = (alu_A[31] != alu_B[31]) && (s[31] != alu_A[31]);
      end
      3'b111: alu_Result = {31'd0, $signed(alu_A) < $signed(alu_B)};
      default: alu_Result = '0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [63:0] ref_product(input logic sg, input logic [31:0] x,
                                               input logic [31:0] y);
    logic signed [63:0] sx, sy;
    if (sg) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Transaction model: 0 idle, 1 calculating, 2 done; result appears when done.
  int          m_phase = 0;
  int          m_steps = 0;
  logic [63:0] m_pending = '0;
  logic [63:0] m_result = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  = 0;
      m_result = '0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase   = 1;
          m_steps   = 0;
          m_pending = ref_product(op_signed, a, b);
        end
        1: begin
          m_steps++;
          if (m_steps == 32) begin
            m_phase  = 2;
            m_result = m_pending;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("busy", {63'd0, busy}, {63'd0, m_phase != 0});
    check("done", {63'd0, done}, {63'd0, m_phase == 2});
    if (m_phase == 1) begin
      check("aluop_calc", {63'd0, alu_ALUop == 3'b010 || alu_ALUop == 3'b110}, 64'd1);
    end else begin
      check("aluop_idle", {61'd0, alu_ALUop}, 64'd0);
      check("alu_ab_idle", {alu_A, alu_B}, 64'd0);
      check("hi_lo", {hi, lo}, m_result);
    end
  end

  // Start one op; expects done after exactly 32 edges following the accept
  // edge (i.e. in the 33rd cycle counting the start cycle).
  task automatic do_op(input logic sg, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic lit, input logic [31:0] eh, input logic [31:0] el);
    int edges;
    start = 1'b1;
    op_signed = sg;
    a = ta;
    b = tb_v;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", 64'(edges), 64'd32);
    if (lit) begin
      check("lit_hi_lo", {hi, lo}, {eh, el});
      check("lit_model", ref_product(sg, ta, tb_v), {eh, el});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] edge_vals [6];
    edge_vals = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000001};
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {59'd0, busy, done, alu_ALUop}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001);
    do_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001);
    do_op(1'b1, 32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    do_op(1'b1, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000);
    do_op(1'b1, 32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000);
    do_op(1'b0, 32'h12345678, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000);
    do_op(1'b1, 32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 32'h00000000);

    // Start during CALC is ignored.
    start = 1'b1; op_signed = 1'b0; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    start = 1'b1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int n = 0;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      check("ignored_start_done", {63'd0, done}, 64'd1);
    end
    check("ignored_start", {hi, lo}, 64'h0000_0000_0000_000F);
    @(posedge clk); #1;

    // Reset mid-operation.
    start = 1'b1; op_signed = 1'b1; a = 32'hDEADBEEF; b = 32'h12345678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_flags", {62'd0, busy, done}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("post_rst_idle", {63'd0, busy}, 64'd0);
    do_op(1'b0, 32'd6, 32'd7, 1'b1, 32'h0, 32'h0000002A);

    // Random and boundary-mixed operands; checked by the per-cycle model.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      do_op(1'($urandom_range(0, 1)), ra, rb, 1'b0, 32'h0, 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
